afe_pulser_sequencer: RTL and testbench

//  Upstream trigger source for afe_pulser in the lclk domain. Produces the

---
 rtl/afe_pulser_sequencer.sv | 153 +++++++++++++++
 tb/tb_afe_pulser_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_pulser_sequencer.sv
// -----------------------------------------------------------------------------
// afe_pulser_sequencer
//
// Trigger source for afe_pulser in the lclk domain. It issues the one-cycle
// trig strobe together with the 16-bit width word afe_pulser samples. Three
// firing modes share one FSM:
//   - single : exactly one pulse, using width_in
//   - burst  : n_pulses_in pulses spaced period_in cycles apart
//   - train  : n_pulses_in == 0, pulses continue until stop
//
// Ports
//   lclk         logic clock; all state changes on posedge
//   lclk_rst     asynchronous, active-high reset
//   start        1-cycle request: begin burst/train (honoured in IDLE only)
//   single       1-cycle request: one pulse (honoured in IDLE only)
//   stop         1-cycle request: abort an active sequence
//   period_in    trig-to-trig spacing in lclk cycles, sampled at start
//   n_pulses_in  burst length, 0 = continuous, sampled at start
//   width_in     width code for afe_pulser, sampled at start/single
//   trig         registered 1-cycle strobe (high while in FIRE)
//   width        registered width word; updated on entry to FIRE, held after
//   busy         high in FIRE and WAIT
//   done         1-cycle strobe in DONE, when a sequence ends
//   pulse_cnt    pulses fired in the current or last sequence
// -----------------------------------------------------------------------------
module afe_pulser_sequencer #(
    parameter int PERIOD_W   = 32,
    parameter int MIN_PERIOD = 8
) (
    input  logic                lclk,
    input  logic                lclk_rst,
    input  logic                start,
    input  logic                single,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [15:0]         n_pulses_in,
    input  logic [15:0]         width_in,
    output logic                trig,
    output logic [15:0]         width,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Sequence configuration captured when a request is accepted.
    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [15:0]         n;
        logic [15:0]         w;
    } seq_cfg_t;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] TWO   = PERIOD_W'(2);

    state_t              state;
    seq_cfg_t            cfg;
    logic [PERIOD_W-1:0] timer;

    logic [PERIOD_W-1:0] period_clamped;
    logic [15:0]         cnt_inc;
    logic                last_pulse;

    always_comb begin
        period_clamped = (period_in < MIN_P) ? MIN_P : period_in;
        cnt_inc        = pulse_cnt + 16'd1;
        // n == 0 means continuous; the count then simply wraps.
        last_pulse     = (cfg.n != 16'd0) && (cnt_inc == cfg.n);
    end

    // Single FSM process. Outputs are registered and set alongside the state
    // transition, so trig/busy/done always reflect the state being entered.
    always_ff @(posedge lclk or posedge lclk_rst) begin
        if (lclk_rst) begin
            state     <= S_IDLE;
            cfg       <= '0;
            timer     <= '0;
            trig      <= 1'b0;
            width     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            trig <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // stop in IDLE masks any request arriving the same cycle
                    if (!stop && (start || single)) begin
                        state     <= S_FIRE;
                        trig      <= 1'b1;
                        busy      <= 1'b1;
                        width     <= width_in;
                        pulse_cnt <= '0;
                        cfg.w     <= width_in;
                        if (start) begin
                            cfg.period <= period_clamped;
                            cfg.n      <= n_pulses_in;
                        end else begin
                            // single leaves the period alone: with n == 1
                            // the FSM never reaches WAIT, so it is unused.
                            cfg.n <= 16'd1;
                        end
                    end
                end

                S_FIRE: begin
                    pulse_cnt <= cnt_inc;
                    // FIRE itself and the WAIT cycle that sees timer==0 make
                    // up the extra two cycles of the period.
                    timer     <= cfg.period - TWO;
                    if (stop || last_pulse) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (stop) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (timer == '0) begin
                        state <= S_FIRE;
                        trig  <= 1'b1;
                        width <= cfg.w;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afe_pulser_sequencer.sv
module tb_afe_pulser_sequencer;

    logic        lclk;
    logic        lclk_rst;
    logic        start;
    logic        single;
    logic        stop;
    logic [31:0] period_in;
    logic [15:0] n_pulses_in;
    logic [15:0] width_in;
    logic        trig;
    logic [15:0] width;
    logic        busy;
    logic        done;
    logic [15:0] pulse_cnt;

    afe_pulser_sequencer #(.PERIOD_W(32), .MIN_PERIOD(8)) dut (
        .lclk        (lclk),
        .lclk_rst    (lclk_rst),
        .start       (start),
        .single      (single),
        .stop        (stop),
        .period_in   (period_in),
        .n_pulses_in (n_pulses_in),
        .width_in    (width_in),
        .trig        (trig),
        .width       (width),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    initial lclk = 1'b0;
    always #5 lclk = ~lclk;

    int cyc = 0;
    always @(posedge lclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] w;
    } trig_exp_t;

    trig_exp_t tq[$];
    int        dq[$];

    typedef struct {
        logic        st;
        logic        sg;
        logic [31:0] period;
        logic [15:0] n;
        logic [15:0] w;
        int          exp_p;
        int          exp_trigs;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    // Output monitor: every trig/done must match the head of its queue.
    always @(negedge lclk) begin
        if (trig) begin
            if (tq.size() == 0) begin
                chk("unexpected_trig", 32'd1, 32'd0);
            end else begin
                trig_exp_t e;
                e = tq.pop_front();
                chk("trig_cycle", cyc, e.cyc);
                chk("trig_width", {16'd0, width}, {16'd0, e.w});
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                int d;
                d = dq.pop_front();
                chk("done_cycle", cyc, d);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle(input string nm);
        int budget = 0;
        while ((tq.size() != 0 || dq.size() != 0) && budget < 5000) begin
            tick();
            budget++;
        end
        chk(nm, budget < 5000, 1);
    endtask

    initial begin
        int c;
        // ---------------- reset ----------------
        lclk_rst = 1'b1;
        start = 0; single = 0; stop = 0;
        period_in = 0; n_pulses_in = 0; width_in = 0;
        repeat (10) tick();
        lclk_rst = 1'b0;
        tick();
        chk("rst_trig", {31'd0, trig}, 0);
        chk("rst_width", {16'd0, width}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pulse_cnt", {16'd0, pulse_cnt}, 0);
        repeat (3) tick();

        // ---------------- vector table ----------------
        vecs[0]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd12, 0, 1, 16'd1};
        vecs[1]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd7,  0, 1, 16'd1};
        vecs[2]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd6,  0, 1, 16'd1};
        vecs[3]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd5,  0, 1, 16'd1};
        vecs[4]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd4,  0, 1, 16'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd3,  0, 1, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd2,  0, 1, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd1,  0, 1, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 32'd99, 16'd7, 16'd0,  0, 1, 16'd1};
        vecs[9]  = '{1'b1, 1'b0, 32'd10, 16'd3, 16'd12,      10, 3, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 32'd3,  16'd2, 16'h1234,     8, 2, 16'd2};
        vecs[11] = '{1'b1, 1'b0, 32'd0,  16'd2, 16'hBEEF,     8, 2, 16'd2};
        vecs[12] = '{1'b1, 1'b0, 32'd1,  16'd3, 16'h0055,     8, 3, 16'd3};
        vecs[13] = '{1'b1, 1'b0, 32'd9,  16'd1, 16'h00A0,     9, 1, 16'd1};
        vecs[14] = '{1'b1, 1'b0, 32'd8,  16'd4, 16'hFFFF,     8, 4, 16'd4};
        vecs[15] = '{1'b1, 1'b0, 32'd25, 16'd2, 16'h0100,    25, 2, 16'd2};
        vecs[16] = '{1'b1, 1'b1, 32'd12, 16'd2, 16'h0777,    12, 2, 16'd2};

        for (int i = 0; i < NV; i++) begin
            start       = vecs[i].st;
            single      = vecs[i].sg;
            period_in   = vecs[i].period;
            n_pulses_in = vecs[i].n;
            width_in    = vecs[i].w;
            c = cyc;
            for (int k = 0; k < vecs[i].exp_trigs; k++)
                tq.push_back('{c + 1 + k * vecs[i].exp_p, vecs[i].w});
            dq.push_back(c + 1 + (vecs[i].exp_trigs - 1) * vecs[i].exp_p + 1);
            tick();
            // mid-sequence changes must have no effect
            start       = 0;
            single      = 0;
            width_in    = ~vecs[i].w;
            period_in   = 32'd2;
            n_pulses_in = 16'd5;
            wait_idle("vec_completes");
            chk("vec_pulse_cnt", {16'd0, pulse_cnt}, {16'd0, vecs[i].exp_cnt});
            chk("vec_busy_idle", {31'd0, busy}, 0);
            chk("vec_width_hold", {16'd0, width}, {16'd0, vecs[i].w});
            repeat (10) tick();
        end

        // ---------------- continuous, clamped, stop in WAIT ----------------
        start = 1; period_in = 32'd3; n_pulses_in = 16'd0; width_in = 16'd9;
        c = cyc;
        tq.push_back('{c + 1, 16'd9});
        tq.push_back('{c + 9, 16'd9});
        tq.push_back('{c + 17, 16'd9});
        dq.push_back(c + 21);
        tick();
        start = 0; width_in = 16'hAAAA;
        repeat (3) tick();
        // requests while busy are ignored
        start = 1; single = 1; period_in = 32'd10; n_pulses_in = 16'd1; width_in = 16'h55;
        tick();
        start = 0; single = 0;
        repeat (15) tick();
        stop = 1;
        tick();
        stop = 0;
        chk("cont_done", {31'd0, done}, 1);
        chk("cont_busy", {31'd0, busy}, 0);
        chk("cont_pulse_cnt", {16'd0, pulse_cnt}, 3);
        repeat (20) tick();

        // ---------------- stop in FIRE ----------------
        start = 1; period_in = 32'd8; n_pulses_in = 16'd0; width_in = 16'h33;
        c = cyc;
        tq.push_back('{c + 1, 16'h33});
        dq.push_back(c + 2);
        tick();
        start = 0; stop = 1;
        tick();
        stop = 0;
        chk("fire_stop_cnt", {16'd0, pulse_cnt}, 1);
        repeat (12) tick();

        // ---------------- stop masks start/single in IDLE ----------------
        start = 1; stop = 1; period_in = 32'd8; n_pulses_in = 16'd2;
        tick();
        chk("idle_stop_busy", {31'd0, busy}, 0);
        start = 0; single = 1;
        tick();
        chk("idle_stop_busy2", {31'd0, busy}, 0);
        single = 0; stop = 0;
        repeat (12) tick();

        // ---------------- async reset mid-WAIT ----------------
        start = 1; period_in = 32'd20; n_pulses_in = 16'd0; width_in = 16'd7;
        c = cyc;
        tq.push_back('{c + 1, 16'd7});
        tick();
        start = 0;
        repeat (4) tick();
        chk("wait_busy_pre", {31'd0, busy}, 1);
        #2;
        lclk_rst = 1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_width", {16'd0, width}, 0);
        chk("arst_pulse_cnt", {16'd0, pulse_cnt}, 0);
        chk("arst_trig", {31'd0, trig}, 0);
        repeat (3) tick();
        lclk_rst = 0;
        repeat (30) tick();

        chk("trig_queue_empty", tq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
